// File: rtl/usb3_buf_out_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb3_buf_out_streamer_pkg
// Brief    : Shared FSM states, keep masks and beat type for the OUT streamer.
// Revision : 1.0 - initial release
// ============================================================================
package usb3_buf_out_streamer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_DRAIN    = 3'd2,
        S_RELEASE  = 3'd3,
        S_WAIT_CLR = 3'd4
    } state_t;

    localparam logic [3:0] C_KEEP_1 = 4'b0001;
    localparam logic [3:0] C_KEEP_2 = 4'b0011;
    localparam logic [3:0] C_KEEP_3 = 4'b0111;
    localparam logic [3:0] C_KEEP_4 = 4'b1111;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    // Byte enables of the final word, selected by the two LSBs of the length.
    function automatic logic [3:0] last_keep(input logic [1:0] len_lsb);
        case (len_lsb)
            2'd1:    return C_KEEP_1;
            2'd2:    return C_KEEP_2;
            2'd3:    return C_KEEP_3;
            default: return C_KEEP_4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb3_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb3_skid_fifo
// Brief    : 2-entry beat FIFO with registered head and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module usb3_skid_fifo
    import usb3_buf_out_streamer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  beat_t      i_push_beat,
    input  logic       i_pop,
    output beat_t      o_head,
    output logic       o_valid,
    output logic [1:0] o_count
);

    beat_t      r_head;
    beat_t      r_tail;
    logic [1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_push_beat;
                    else                 r_tail <= i_push_beat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push keep the occupancy unchanged.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_beat;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/usb3_buf_out_streamer.sv
`default_nettype none
// ============================================================================
// Module   : usb3_buf_out_streamer
// Brief    : Reads a received OUT packet from the core buffer RAM, streams it
//            as valid/ready beats with keep/last, then re-arms the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module usb3_buf_out_streamer
    import usb3_buf_out_streamer_pkg::*;
#(
    parameter int ZLP_EN  = 1,
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [8:0]  buf_out_addr,
    input  logic [31:0] buf_out_q,
    input  logic [10:0] buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [31:0] src_data,
    output logic [3:0]  src_keep,
    output logic        src_last,
    output logic        len_err,
    output logic [15:0] pkt_count
);

    localparam logic [10:0] C_MAX_LEN = 11'(MAX_LEN);

    state_t      r_state;
    logic [8:0]  r_addr;
    logic [9:0]  r_words;
    logic [1:0]  r_len_lsb;
    logic        r_inflight;
    logic        r_inflight_last;
    logic        r_arm;
    logic        r_len_err;
    logic [15:0] r_pkt_count;

    logic [10:0] w_len;
    logic [9:0]  w_words;
    logic [2:0]  w_occ;
    logic [1:0]  w_count;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_last_issue;
    logic        w_zlp_push;
    beat_t       w_push_beat;
    beat_t       w_head;

    assign w_len   = (buf_out_len > C_MAX_LEN) ? C_MAX_LEN : buf_out_len;
    assign w_words = 10'((12'(w_len) + 12'd3) >> 2);

    assign w_pop = src_valid & src_ready;
    // Occupancy the FIFO will have once this cycle's pop and any in-flight read settle.
    assign w_occ        = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == S_READ) && (w_occ < 3'd2);
    assign w_last_issue = w_issue && ({1'b0, r_addr} == (r_words - 10'd1));
    assign w_zlp_push   = (ZLP_EN != 0) && (r_state == S_IDLE) && buf_out_hasdata
                          && (w_len == 11'd0);
    assign w_push       = r_inflight | w_zlp_push;

    always_comb begin
        w_push_beat = '0;
        if (w_zlp_push) begin
            w_push_beat.last = 1'b1;
        end else begin
            w_push_beat.data = buf_out_q;
            w_push_beat.keep = r_inflight_last ? last_keep(r_len_lsb) : C_KEEP_4;
            w_push_beat.last = r_inflight_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_addr          <= 9'd0;
            r_words         <= 10'd0;
            r_len_lsb       <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_arm           <= 1'b0;
            r_len_err       <= 1'b0;
            r_pkt_count     <= 16'd0;
        end else begin
            r_len_err       <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            case (r_state)
                S_IDLE: begin
                    r_addr <= 9'd0;
                    if (buf_out_hasdata) begin
                        r_words   <= w_words;
                        r_len_lsb <= w_len[1:0];
                        r_len_err <= (buf_out_len > C_MAX_LEN);
                        if (w_len == 11'd0) begin
                            if (ZLP_EN != 0) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state <= S_RELEASE;
                                r_arm   <= 1'b1;
                            end
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_last_issue)  r_state <= S_DRAIN;
                    else if (w_issue)  r_addr  <= r_addr + 9'd1;
                end
                S_DRAIN: begin
                    if ((w_count == 2'd0) && !r_inflight) begin
                        r_state <= S_RELEASE;
                        r_arm   <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (buf_out_arm_ack) begin
                        r_arm       <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_state     <= S_WAIT_CLR;
                    end
                end
                S_WAIT_CLR: begin
                    // The core may still show the old hasdata level for a cycle after ack.
                    if (!buf_out_hasdata) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    usb3_skid_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (src_valid),
        .o_count     (w_count)
    );

    assign buf_out_addr = r_addr;
    assign buf_out_arm  = r_arm;
    assign len_err      = r_len_err;
    assign pkt_count    = r_pkt_count;
    assign src_data     = w_head.data;
    assign src_keep     = w_head.keep;
    assign src_last     = w_head.last;

endmodule
`default_nettype wire
